sbox_inv_layer: RTL
===================

Name: sbox_inv_layer

Overview:
- Inverse PRESENT substitution layer for the decryption datapath: applies the 4-bit inverse S-box to every nibble of a WIDTH-bit state word.
- Iterative: LANES nibbles per clock, in place in a shift register, using ready/valid handshakes on both sides.
- Sits between the inverse permutation layer and the round-key XOR in the decryption round loop.
- It is the decrypt-side counterpart of the existing forward sbox.

Parameters:
- WIDTH, 64, state width in bits; must be a multiple of 4*LANES.
- LANES, 1, number of nibbles substituted per cycle; must divide WIDTH/4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  req_data is valid.
- req_ready  output  1  block can accept a request this cycle.
- req_data  input  WIDTH  ciphertext-side state word.
- rsp_valid  output  1  rsp_data holds a completed result.
- rsp_ready  input  1  consumer accepts rsp_data this cycle.
- rsp_data  output  WIDTH  inverse-substituted state word.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, rst).
  - While rst=1: state=IDLE, count=0, shift register=0, rsp_valid=0, rsp_data=0.
  - Reset mid-operation aborts the word; no partial result is ever presented.
- Inverse table (in→out), hex:
  - 0→5, 1→E, 2→F, 3→8, 4→C, 5→1, 6→2, 7→D
  - 8→B, 9→4, A→6, B→3, C→0, D→7, E→9, F→A
- FSM states IDLE, BUSY, DONE.
  - IDLE: req_ready=1, rsp_valid=0. On req_valid&req_ready, load req_data into the shift register, set count=0, go to BUSY.
  - BUSY: req_ready=0, rsp_valid=0. Each cycle:
    - substitute the LANES least-significant nibbles;
    - rotate the register right by 4*LANES bits, placing the substituted nibbles at the top;
    - increment count.
    - When count reaches WIDTH/(4*LANES)-1 on this edge, go to DONE.
  - DONE: rsp_valid=1 and rsp_data=register, held stable until rsp_ready=1.
    - On rsp_valid&rsp_ready, go to IDLE, or directly to BUSY if a new request is accepted on the same edge.
- Order and output mapping:
  - Nibbles are processed LSB-first.
  - After the full word, every nibble is back in its original position: rsp_data[4i+3:4i] = inv(req_data[4i+3:4i]).
- Latency:
  - Handshake on edge k gives rsp_valid high after edge k+WIDTH/(4*LANES).
  - Defaults: 16 cycles.
- req_ready = (state==IDLE) | (state==DONE & rsp_ready).
  - This gives back-to-back throughput with one DONE cycle per word under continuous rsp_ready.
- Back-pressure: rsp_ready=0 in DONE holds the result and keeps req_ready=0 indefinitely. No data is lost or overwritten.
- Input rules:
  - req_data is sampled only on the accepting edge; later changes are ignored.
  - req_valid in BUSY is not accepted.
- Width rules:
  - count is clog2(WIDTH/(4*LANES)) bits wide, minimum 1.
  - No wrap: count is cleared on every load.

Decomposition:
- Shared package: FSM state encoding (IDLE/BUSY/DONE) and the inverse S-box constant table, which both this block and the key schedule's inverse checks use.
- One natural sub-module: sbox_inv, a combinational 4-bit inverse lookup. Instantiate LANES copies.

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle → rsp_valid=0, rsp_data=0, req_ready=1 immediately, without waiting for a clock edge.
- All zero: req_data=0x0000000000000000 → after 16 cycles rsp_data=0x5555555555555555, rsp_valid=1.
- Table sweep: req_data=0xFEDCBA9876543210 → rsp_data=0xA970364BD21C8FE5.
- Round trip with forward sbox output: req_data=0x21748FE3DA09B65C → rsp_data=0xFEDCBA9876543210.
- Back-pressure then back-to-back:
  - Hold rsp_ready=0 for 5 cycles in DONE → rsp_data stable and req_ready=0 throughout.
  - Then rsp_ready=1 with req_valid=1 → same-edge accept, next result after 16 more cycles.
- Reset mid-operation: rst pulse at BUSY cycle 7 → IDLE, no rsp_valid. A new request of 0xFFFFFFFFFFFFFFFF then yields 0xAAAAAAAAAAAAAAAA.

Source files
------------

// File: rtl/sbox_inv_layer_pkg.sv
// Shared definitions for the PRESENT inverse substitution datapath: FSM state
// encoding and the 4-bit inverse S-box table.
package sbox_inv_layer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Index is the S-box output nibble, entry is the original input nibble.
  localparam logic [3:0] SboxInvTable [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  function automatic logic [3:0] sbox_inv_lookup(input logic [3:0] nibble);
    return SboxInvTable[nibble];
  endfunction

  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/sbox_inv.sv
// Combinational 4-bit PRESENT inverse S-box lookup.
module sbox_inv
  import sbox_inv_layer_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_nibble = sbox_inv_lookup(i_nibble);
  end

endmodule

// File: rtl/sbox_inv_layer.sv
// Iterative inverse S-box layer: LANES nibbles per clock, rotated in place through a
// shift register so every nibble returns to its original position after a full word.
module sbox_inv_layer
  import sbox_inv_layer_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
);

  localparam int unsigned LaneBits = 4 * LANES;
  localparam int unsigned Steps    = WIDTH / LaneBits;
  localparam int unsigned CntW     = cnt_width(Steps);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  state_e              r_state, w_state_next;
  logic [WIDTH-1:0]    r_shift, w_shift_next;
  logic [CntW-1:0]     r_count, w_count_next;
  logic [LaneBits-1:0] w_subs;
  logic [WIDTH-1:0]    w_rotated;
  logic                w_req_fire;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_inv u_sbox_inv (
      .i_nibble (r_shift[4*g +: 4]),
      .o_nibble (w_subs[4*g +: 4])
    );
  end

  // Substituted low nibbles re-enter at the top so the word comes full circle.
  if (Steps == 1) begin : g_rot_single
    assign w_rotated = w_subs;
  end else begin : g_rot_multi
    assign w_rotated = {w_subs, r_shift[WIDTH-1:LaneBits]};
  end

  always_comb begin
    req_ready  = (r_state == StIdle) | ((r_state == StDone) & rsp_ready);
    rsp_valid  = (r_state == StDone);
    rsp_data   = rsp_valid ? r_shift : '0;
    w_req_fire = req_valid & req_ready;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_count_next = r_count;
    unique case (r_state)
      StIdle: begin
        if (w_req_fire) begin
          w_shift_next = req_data;
          w_count_next = '0;
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        w_shift_next = w_rotated;
        w_count_next = r_count + CntW'(1);
        if (r_count == LastCnt) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          if (w_req_fire) begin
            w_shift_next = req_data;
            w_count_next = '0;
            w_state_next = StBusy;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_count <= w_count_next;
    end
  end

endmodule
